// File: rtl/tlb_ctrl_if.sv
// Requester-side handshake bundle for tlb_ctrl: the translate request channel and the PTE response channel.
interface tlb_ctrl_if #(
  parameter int VPN_W = 20,
  parameter int PTE_W = 32
);
  logic             req_valid_i;
  logic [VPN_W-1:0] req_vpn_i;
  logic             req_ready_o;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [PTE_W-1:0] rsp_pte_o;
  logic             rsp_fault_o;

  modport slave (
    input  req_valid_i, req_vpn_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_pte_o, rsp_fault_o
  );

  modport master (
    output req_valid_i, req_vpn_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_pte_o, rsp_fault_o
  );
endinterface

// File: rtl/tlb_ctrl.sv
// TLB lookup/refill controller: tag-RAM probe, page-table walk on miss, refill, response, flush handling.
// state     | meaning
// IDLE      | ready for a request
// LOOKUP    | tag RAM addressed by vpn_q, hit/miss decided
// WALK_REQ  | walk request presented to PTW
// WALK_WAIT | waiting for PTW response
// REFILL    | write walked PTE into tag RAM
// RESP      | response held until accepted
module tlb_ctrl #(
  parameter int IDX_W = 6,
  parameter int VPN_W = 20,
  parameter int PTE_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  tlb_ctrl_if.slave              req,
  output logic                   ptw_req_valid_o,
  output logic [VPN_W-1:0]       ptw_req_vpn_o,
  input  logic                   ptw_req_ready_i,
  input  logic                   ptw_rsp_valid_i,
  input  logic [PTE_W-1:0]       ptw_rsp_pte_i,
  input  logic                   ptw_rsp_fault_i,
  output logic [IDX_W-1:0]       tr_idx_o,
  output logic [VPN_W-IDX_W-1:0] tr_tag_o,
  output logic [PTE_W-1:0]       tr_payload_o,
  output logic                   tr_we_o,
  output logic                   tr_valid_o,
  input  logic                   tr_hit_i,
  input  logic [PTE_W-1:0]       tr_payload_i,
  input  logic                   flush_i,
  output logic [CNT_W-1:0]       hit_cnt_o,
  output logic [CNT_W-1:0]       miss_cnt_o
);
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP} state_t;

  state_t             state, state_nxt;
  logic [VPN_W-1:0]   vpn_q;
  logic [PTE_W-1:0]   pte_q;
  logic [PTE_W-1:0]   rsp_pte_q;
  logic               rsp_fault_q;
  logic [LINES-1:0]   shadow;
  logic               flush_pend;
  logic               req_ready;
  logic               hit;
  logic               refill_we;

  assign tr_idx_o         = vpn_q[IDX_W-1:0];
  assign tr_tag_o         = vpn_q[VPN_W-1:IDX_W];
  assign tr_payload_o     = pte_q;
  assign ptw_req_vpn_o    = vpn_q;
  assign req.req_ready_o  = req_ready;
  assign req.rsp_valid_o  = (state == RESP);
  assign req.rsp_pte_o    = rsp_pte_q;
  assign req.rsp_fault_o  = rsp_fault_q;

  always_comb begin
    state_nxt       = state;
    req_ready       = (state == IDLE) && !flush_i;
    hit             = 1'b0;
    refill_we       = 1'b0;
    ptw_req_valid_o = 1'b0;
    case (state)
      IDLE:      if (req.req_valid_i && req_ready) state_nxt = LOOKUP;
      LOOKUP: begin
        hit       = tr_hit_i && shadow[tr_idx_o] && !flush_i;
        state_nxt = hit ? RESP : WALK_REQ;
      end
      WALK_REQ: begin
        ptw_req_valid_o = 1'b1;
        if (ptw_req_ready_i) state_nxt = WALK_WAIT;
      end
      WALK_WAIT: if (ptw_rsp_valid_i) state_nxt = ptw_rsp_fault_i ? RESP : REFILL;
      REFILL: begin
        // a flush seen anywhere during the walk makes the walked PTE stale for caching
        refill_we = !(flush_pend || flush_i);
        state_nxt = RESP;
      end
      RESP:      if (req.rsp_ready_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign tr_we_o    = refill_we;
  assign tr_valid_o = refill_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vpn_q       <= '0;
      pte_q       <= '0;
      rsp_pte_q   <= '0;
      rsp_fault_q <= 1'b0;
      shadow      <= '0;
      flush_pend  <= 1'b0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
    end else begin
      if (state == IDLE && req.req_valid_i && req_ready) vpn_q <= req.req_vpn_i;

      if (flush_i)        shadow <= '0;
      else if (refill_we) shadow[tr_idx_o] <= 1'b1;

      if (state != IDLE && state_nxt == IDLE)
        flush_pend <= 1'b0;
      else if (flush_i && (state == WALK_REQ || state == WALK_WAIT || state == REFILL))
        flush_pend <= 1'b1;

      case (state)
        LOOKUP: begin
          if (hit) begin
            rsp_pte_q   <= tr_payload_i;
            rsp_fault_q <= 1'b0;
            if (hit_cnt_o != {CNT_W{1'b1}}) hit_cnt_o <= hit_cnt_o + CNT_W'(1);
          end else if (miss_cnt_o != {CNT_W{1'b1}}) begin
            miss_cnt_o <= miss_cnt_o + CNT_W'(1);
          end
        end
        WALK_WAIT: begin
          if (ptw_rsp_valid_i) begin
            if (ptw_rsp_fault_i) begin
              rsp_pte_q   <= '0;
              rsp_fault_q <= 1'b1;
            end else begin
              pte_q <= ptw_rsp_pte_i;
            end
          end
        end
        REFILL: begin
          rsp_pte_q   <= pte_q;
          rsp_fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 6, giving the tag-RAM index width (64 lines).
REQ-002 SHALL have parameter VPN_W, default 20, giving the virtual page number width.
REQ-003 SHALL have parameter PTE_W, default 32, giving the PTE payload width.
REQ-004 SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-005 SHALL have ports: clk in 1, clock; resetn in 1, reset. Reset is resetn, asynchronous, active-low; the clock is clk.
REQ-006 SHALL have requester ports: req_valid_i in 1; req_vpn_i in VPN_W; req_ready_o out 1; rsp_valid_o out 1; rsp_ready_i in 1; rsp_pte_o out PTE_W; rsp_fault_o out 1.
REQ-007 SHALL have page-table-walker ports: ptw_req_valid_o out 1; ptw_req_vpn_o out VPN_W; ptw_req_ready_i in 1; ptw_rsp_valid_i in 1; ptw_rsp_pte_i in PTE_W; ptw_rsp_fault_i in 1.
REQ-008 SHALL have tag-RAM ports: tr_idx_o out IDX_W; tr_tag_o out VPN_W-IDX_W; tr_payload_o out PTE_W; tr_we_o out 1; tr_valid_o out 1; tr_hit_i in 1; tr_payload_i in PTE_W (combinational read of the addressed line).
REQ-009 SHALL have ports: flush_i in 1, TLB invalidate-all; hit_cnt_o out CNT_W; miss_cnt_o out CNT_W.

Function
REQ-010 SHALL implement the FSM states IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP.
REQ-011 SHALL drive req_ready_o = (state==IDLE) && !flush_i; on req_valid_i && req_ready_o, SHALL latch req_vpn_i into vpn_q and move to LOOKUP.
REQ-012 SHALL drive tr_idx_o = vpn_q[IDX_W-1:0] and tr_tag_o = vpn_q[VPN_W-1:IDX_W] continuously.
REQ-013 SHALL hold a LINES-bit shadow valid bitmap; in LOOKUP, hit = tr_hit_i && shadow[tr_idx_o] && !flush_i.
REQ-014 On a LOOKUP hit, SHALL register rsp_pte_o = tr_payload_i and rsp_fault_o = 0, increment hit_cnt_o, and go to RESP; request-accept to rsp_valid_o latency is 2 cycles.
REQ-015 On a LOOKUP miss, SHALL increment miss_cnt_o and go to WALK_REQ.
REQ-016 In WALK_REQ, SHALL assert ptw_req_valid_o with ptw_req_vpn_o = vpn_q, held stable until ptw_req_ready_i; on that handshake cycle, SHALL go to WALK_WAIT.
REQ-017 In WALK_WAIT, SHALL ignore all ptw_rsp_* until ptw_rsp_valid_i; fault=1 -> rsp_pte_o=0, rsp_fault_o=1, go to RESP with no refill; fault=0 -> latch pte, go to REFILL.
REQ-018 In REFILL (exactly 1 cycle), SHALL assert tr_we_o = tr_valid_o = 1 with tr_payload_o = latched pte, set shadow[idx], and load rsp_pte_o with rsp_fault_o = 0, then go to RESP.
REQ-019 In RESP, SHALL hold rsp_valid_o=1 and rsp_pte_o/rsp_fault_o stable until rsp_ready_i; on that handshake cycle, SHALL return to IDLE.
REQ-020 flush_i SHALL be sampled in every state; it SHALL clear the whole shadow bitmap at the clock edge, and no tag-RAM write is needed.
REQ-021 flush_i in WALK_REQ, WALK_WAIT or REFILL SHALL set flush_pend; while flush_pend or flush_i is set, REFILL SHALL drive tr_we_o=0 and leave shadow unchanged, but still deliver the PTE response.
REQ-022 flush_pend SHALL clear on entry to IDLE.
REQ-023 flush_i coincident with req_valid_i in IDLE SHALL win: the request is not accepted that cycle.
REQ-024 hit_cnt_o and miss_cnt_o SHALL saturate at all-ones and never wrap.
REQ-025 tr_we_o and tr_valid_o SHALL be 0 in every state except REFILL.

Reset
REQ-026 On resetn low, SHALL asynchronously force state=IDLE, shadow=0, flush_pend=0, vpn_q=0, counters=0, rsp_pte_o=0, and all valid/we/fault outputs to 0; req_ready_o is 1 after release when flush_i=0.
REQ-027 Reset mid-walk SHALL abandon the transaction; a late ptw_rsp_valid_i in IDLE SHALL be ignored, with no write and no response.

Verification
REQ-028 Miss then hit: vpn 0x12345, PTW returns 0xCAFE0001 -> one ptw_req, one tr_we at idx 0x05, tag 0x48D; repeating the request -> rsp 0xCAFE0001 at 2 cycles, hit_cnt=1, miss_cnt=1.
REQ-029 Fault: PTW returns fault=1 -> rsp_fault_o=1, rsp_pte_o=0, no tr_we; the same vpn misses again.
REQ-030 Flush during WALK_WAIT: rsp still delivers the PTE, tr_we_o stays 0; the next request to the same vpn misses.
REQ-031 Backpressure: ptw_req_ready_i low 5 cycles and rsp_ready_i low 3 cycles -> ptw_req_vpn_o and rsp_pte_o stay stable; exactly one transaction completes.
REQ-032 Saturation: CNT_W=4 with 20 misses -> miss_cnt_o stays at 0xF.
REQ-033 Reset asserted in WALK_WAIT, then ptw_rsp_valid_i pulsed -> all outputs return to reset values; no rsp_valid_o, no tr_we_o.
